// File: rtl/key_event_sched_pkg.sv
// Shared types and default timing for the key event scheduler.
// Channel FSM states, FIFO event record, 125 MHz timing defaults.
package key_event_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    REPEAT
  } chan_state_t;

  localparam int EVT_CODE_W = 8;

  typedef struct packed {
    logic [EVT_CODE_W-1:0] code;
    logic                  is_long;
  } evt_t;

  localparam int DEF_LONG_CNT   = 125_000_000;
  localparam int DEF_REPEAT_CNT = 25_000_000;

endpackage

// File: rtl/key_event_sched_if.sv
// Key event stream: valid/ready handshake plus status flags.
// master = scheduler (drives event), slave = consumer (drives ready).
interface key_event_sched_if #(
  parameter int CODE_W = 3
);
  logic              evt_valid;
  logic              evt_ready;
  logic [CODE_W-1:0] evt_code;
  logic              evt_long;
  logic              evt_ovf;
  logic              fifo_full;

  modport master (
    output evt_valid,
    output evt_code,
    output evt_long,
    output evt_ovf,
    output fifo_full,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_code,
    input  evt_long,
    input  evt_ovf,
    input  fifo_full,
    output evt_ready
  );
endinterface

// File: rtl/key_evt_chan.sv
// Per-key press / long-press / auto-repeat detector.
// Ports: clk, rst_n, key_lvl, key_prev in; raise, raise_long out.
module key_evt_chan
  import key_event_sched_pkg::*;
#(
  parameter int LONG_CNT   = DEF_LONG_CNT,
  parameter int REPEAT_CNT = DEF_REPEAT_CNT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_lvl,
  input  logic key_prev,
  output logic raise,
  output logic raise_long
);

  localparam int CNT_MAX =
    (LONG_CNT > REPEAT_CNT) ? LONG_CNT : REPEAT_CNT;
  localparam int CNT_W =
    (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] LONG_T =
    CNT_W'(LONG_CNT - 1);
  localparam logic [CNT_W-1:0] REP_T =
    CNT_W'(REPEAT_CNT - 1);

  chan_state_t      state;
  logic [CNT_W-1:0] cnt;
  logic             press;
  logic             long_tc;
  logic             rep_tc;

  assign press   = key_lvl & ~key_prev;
  assign long_tc = (cnt == LONG_T);
  assign rep_tc  = (cnt == REP_T);

  // Events fire in the same cycle the condition is
  // sampled so the pending flag sets on that edge.
  always_comb begin
    raise      = 1'b0;
    raise_long = 1'b0;
    unique case (state)
      IDLE: begin
        raise = press;
      end
      HOLD: begin
        raise      = key_lvl & long_tc;
        raise_long = key_lvl & long_tc;
      end
      REPEAT: begin
        raise      = key_lvl & rep_tc;
        raise_long = key_lvl & rep_tc;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (press) begin
            state <= HOLD;
            cnt   <= '0;
          end
        end
        HOLD: begin
          if (!key_lvl) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (long_tc) begin
            state <= REPEAT;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        REPEAT: begin
          if (!key_lvl) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (rep_tc) begin
            cnt <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/key_event_sched.sv
// Key event scheduler: per-key detectors, priority arbiter, event FIFO.
// Ports: clk, rst_n, key_lvl[NKEY] in; evt (master) event stream out.
module key_event_sched
  import key_event_sched_pkg::*;
#(
  parameter int NKEY       = 4,
  parameter int CODE_W     = 3,
  parameter int LONG_CNT   = DEF_LONG_CNT,
  parameter int REPEAT_CNT = DEF_REPEAT_CNT,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NKEY-1:0]       key_lvl,
  key_event_sched_if.master     evt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  logic [NKEY-1:0] key_prev;
  logic [NKEY-1:0] raise;
  logic [NKEY-1:0] raise_long;
  logic [NKEY-1:0] pend;
  logic [NKEY-1:0] pend_long;
  logic [NKEY-1:0] gnt;
  logic            found;
  logic            push;
  logic            pop;
  logic            push_ok;
  logic            full;
  logic            ovf_q;
  evt_t            wr_ent;
  evt_t            head;
  evt_t            mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     cnt;
  logic            unused_hi;

  // All ones at reset: a key held through reset must
  // be released before it can produce an event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) key_prev <= '1;
    else        key_prev <= key_lvl;
  end

  for (genvar g = 0; g < NKEY; g++) begin : g_chan
    key_evt_chan #(
      .LONG_CNT   (LONG_CNT),
      .REPEAT_CNT (REPEAT_CNT)
    ) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .key_lvl    (key_lvl[g]),
      .key_prev   (key_prev[g]),
      .raise      (raise[g]),
      .raise_long (raise_long[g])
    );
  end

  assign full    = (cnt == FULL_CNT);
  assign pop     = (cnt != '0) & evt.evt_ready;
  assign push_ok = ~full | pop;

  // Lowest index pending flag wins.
  always_comb begin
    gnt    = '0;
    wr_ent = '0;
    found  = 1'b0;
    for (int i = 0; i < NKEY; i++) begin
      if (pend[i] && !found) begin
        found          = 1'b1;
        wr_ent.code    = EVT_CODE_W'(i);
        wr_ent.is_long = pend_long[i];
        gnt[i]         = push_ok;
      end
    end
  end

  assign push = found & push_ok;

  // A flag granted on the edge it is re-raised
  // stays set; otherwise a re-raise is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend      <= '0;
      pend_long <= '0;
      ovf_q     <= 1'b0;
    end else begin
      for (int i = 0; i < NKEY; i++) begin
        if (raise[i] && (!pend[i] || gnt[i])) begin
          pend[i]      <= 1'b1;
          pend_long[i] <= raise_long[i];
        end else if (gnt[i]) begin
          pend[i] <= 1'b0;
        end
      end
      ovf_q <= |(raise & pend & ~gnt);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wr_ent;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        cnt <= cnt + (AW+1)'(1);
      end else if (pop && !push) begin
        cnt <= cnt - (AW+1)'(1);
      end
    end
  end

  assign head      = mem[rd_ptr];
  assign unused_hi = |(head.code >> CODE_W);

  assign evt.evt_valid = (cnt != '0);
  assign evt.evt_code  = head.code[CODE_W-1:0];
  assign evt.evt_long  = head.is_long;
  assign evt.evt_ovf   = ovf_q;
  assign evt.fifo_full = full;

endmodule

// File: tb/tb_key_event_sched.sv
// Self-checking bench for key_event_sched.
// Table vectors plus hand sequences, scoreboard queue on pops.
`timescale 1ns/1ps
module tb_key_event_sched;
  import key_event_sched_pkg::*;

  localparam int NKEY   = 4;
  localparam int CODE_W = 3;
  localparam int LONG   = 10;
  localparam int REP    = 4;
  localparam int DEPTH  = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NKEY-1:0] key_lvl = '0;

  key_event_sched_if #(.CODE_W(CODE_W)) evt_if();

  key_event_sched #(
    .NKEY       (NKEY),
    .CODE_W     (CODE_W),
    .LONG_CNT   (LONG),
    .REPEAT_CNT (REP),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .key_lvl (key_lvl),
    .evt     (evt_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    int code;
    int lng;
  } exp_t;

  typedef struct {
    int key;
    int hold;
    int n_long;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[5];
  int   checks = 0;
  int   failures = 0;

  task automatic check(string name, int act, int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(int code, int lng);
    exp_t e;
    e.code = code;
    e.lng  = lng;
    exp_q.push_back(e);
  endtask

  task automatic drain(string name, int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check({name, "_drained"}, exp_q.size(), 0);
    exp_q.delete();
    tick(4);
    check({name, "_idle"}, int'(evt_if.evt_valid), 0);
  endtask

  task automatic check_zero(string name);
    check({name, "_valid"}, int'(evt_if.evt_valid), 0);
    check({name, "_code"}, int'(evt_if.evt_code), 0);
    check({name, "_long"}, int'(evt_if.evt_long), 0);
    check({name, "_ovf"}, int'(evt_if.evt_ovf), 0);
    check({name, "_full"}, int'(evt_if.fifo_full), 0);
  endtask

  // Scoreboard: a pop happens on the next edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && evt_if.evt_valid && evt_if.evt_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_event code=%0d long=%0d required=none",
                 evt_if.evt_code, evt_if.evt_long);
      end else begin
        e = exp_q.pop_front();
        check("evt_code", int'(evt_if.evt_code), e.code);
        check("evt_long", int'(evt_if.evt_long), e.lng);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{key: 2, hold: 5,  n_long: 0};
    vecs[1] = '{key: 0, hold: 30, n_long: 5};
    vecs[2] = '{key: 1, hold: 11, n_long: 1};
    vecs[3] = '{key: 3, hold: 10, n_long: 0};
    vecs[4] = '{key: 2, hold: 15, n_long: 2};

    evt_if.evt_ready = 1'b1;
    #2;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick(2);

    // Latency of a single short press.
    push_exp(2, 0);
    key_lvl[2] = 1'b1;
    tick();
    check("t1_valid_at_k", int'(evt_if.evt_valid), 0);
    tick();
    check("t1_valid_at_k1", int'(evt_if.evt_valid), 1);
    check("t1_code_at_k1", int'(evt_if.evt_code), 2);
    tick(3);
    key_lvl[2] = 1'b0;
    drain("t1", 20);

    // Press/long/repeat table.
    for (int v = 0; v < 5; v++) begin
      push_exp(vecs[v].key, 0);
      for (int n = 0; n < vecs[v].n_long; n++) begin
        push_exp(vecs[v].key, 1);
      end
      key_lvl[vecs[v].key] = 1'b1;
      tick(vecs[v].hold);
      key_lvl[vecs[v].key] = 1'b0;
      drain($sformatf("vec%0d", v), vecs[v].hold + 20);
    end

    // Simultaneous presses, priority order.
    push_exp(0, 0);
    push_exp(1, 0);
    push_exp(3, 0);
    key_lvl = 4'b1011;
    tick();
    tick();
    check("t3_first", int'(evt_if.evt_code), 0);
    tick();
    check("t3_second", int'(evt_if.evt_code), 1);
    tick();
    check("t3_third", int'(evt_if.evt_code), 3);
    check("t3_third_valid", int'(evt_if.evt_valid), 1);
    key_lvl = '0;
    drain("t3", 20);

    // Fill FIFO, pending flag, overflow.
    evt_if.evt_ready = 1'b0;
    push_exp(0, 0);
    push_exp(1, 0);
    push_exp(2, 0);
    push_exp(3, 0);
    key_lvl = 4'b1111;
    tick(2);
    key_lvl = '0;
    tick(4);
    check("t4_full", int'(evt_if.fifo_full), 1);
    check("t4_head", int'(evt_if.evt_code), 0);
    push_exp(0, 0);
    key_lvl[0] = 1'b1;
    tick(2);
    key_lvl[0] = 1'b0;
    tick(2);
    check("t4_no_ovf_yet", int'(evt_if.evt_ovf), 0);
    check("t4_still_full", int'(evt_if.fifo_full), 1);
    key_lvl[0] = 1'b1;
    tick();
    check("t4_ovf_pulse", int'(evt_if.evt_ovf), 1);
    tick();
    check("t4_ovf_clear", int'(evt_if.evt_ovf), 0);
    key_lvl[0] = 1'b0;
    tick(2);
    check("t4_head_stable", int'(evt_if.evt_code), 0);
    evt_if.evt_ready = 1'b1;
    drain("t4", 30);

    // Pop and push on the same edge while full.
    evt_if.evt_ready = 1'b0;
    push_exp(0, 0);
    push_exp(2, 0);
    push_exp(3, 0);
    key_lvl = 4'b1101;
    tick(2);
    key_lvl = '0;
    tick();
    push_exp(0, 0);
    key_lvl[0] = 1'b1;
    tick(2);
    key_lvl = '0;
    tick(4);
    check("t5_full", int'(evt_if.fifo_full), 1);
    push_exp(1, 0);
    key_lvl[1] = 1'b1;
    tick(2);
    key_lvl = '0;
    tick(2);
    check("t5_full_pend", int'(evt_if.fifo_full), 1);
    evt_if.evt_ready = 1'b1;
    tick();
    evt_if.evt_ready = 1'b0;
    check("t5_full_after_swap", int'(evt_if.fifo_full), 1);
    check("t5_new_head", int'(evt_if.evt_code), 2);
    check("t5_ovf", int'(evt_if.evt_ovf), 0);
    tick(2);
    evt_if.evt_ready = 1'b1;
    drain("t5", 30);

    // Reset mid-HOLD with the key held.
    push_exp(2, 0);
    key_lvl[2] = 1'b1;
    drain("t6a", 10);
    rst_n = 1'b0;
    #1;
    check_zero("t6_rst");
    repeat (2) @(posedge clk);
    #1;
    check_zero("t6_rst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    tick(20);
    check("t6_no_evt", int'(evt_if.evt_valid), 0);
    key_lvl[2] = 1'b0;
    tick(2);
    push_exp(2, 0);
    key_lvl[2] = 1'b1;
    tick(3);
    key_lvl[2] = 1'b0;
    drain("t6b", 20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/key_event_sched.md
Name: key_event_sched

Overview:
- Sequences the debounced key levels of the vending front panel into one ordered stream of key events.
- Detects presses, long presses and auto-repeat per key.
- Arbitrates simultaneous events by fixed priority and buffers them in a small FIFO.
- Sits between the per-key debounce stage and the coin/selection control FSM, which consumes events via valid/ready.

Parameters:
- NKEY, 4, number of key channels (2..8).
- CODE_W, 3, width of evt_code; must satisfy 2**CODE_W >= NKEY.
- LONG_CNT, 125_000_000, cycles a key must stay held after its press event before the long event (1 s at 125 MHz).
- REPEAT_CNT, 25_000_000, cycles between auto-repeat long events while still held (200 ms).
- FIFO_DEPTH, 4, event FIFO entries (power of 2).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- key_lvl  in  NKEY  debounced key levels; 1 = stably pressed.
- evt_ready  in  1  consumer accepts the head event this cycle.
- evt_valid  out  1  head event available.
- evt_code  out  CODE_W  index of the key that produced the head event.
- evt_long  out  1  head event is long/repeat (1) or short press (0).
- evt_ovf  out  1  one-cycle pulse: an event was dropped.
- fifo_full  out  1  FIFO holds FIFO_DEPTH entries.

Behaviour:
- Reset (async assert, sync release):
  - evt_valid=0, evt_code=0, evt_long=0, evt_ovf=0, fifo_full=0.
  - FIFO empty; all pending flags 0; all channel FSMs in IDLE; counters 0.
  - key_prev resets to all ones, so a key held through reset produces no event until it is released and pressed again.
- Per-channel FSM, one per key:
  - IDLE: key_lvl=1 and key_prev=0 -> raise short event, cnt=0, go HOLD.
  - HOLD: cnt increments each cycle. At cnt==LONG_CNT-1 -> raise long event, cnt=0, go REPEAT.
  - REPEAT: at cnt==REPEAT_CNT-1 -> raise long event, cnt=0, stay in REPEAT.
  - key_lvl=0 in HOLD or REPEAT -> IDLE, cnt=0, no event. Release has priority over a coincident terminal count.
- Pending flags:
  - Raising an event sets pend[i] and records long_i.
  - If pend[i] is already set when a new event is raised, the new event is dropped, evt_ovf pulses for one cycle, and the older event is kept.
- Arbiter:
  - Each cycle, the lowest-index set pend[i] is granted if push is allowed.
  - Push is allowed when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
  - The granted entry is {i, long_i}; pend[i] clears at the same edge.
  - Only one push per cycle.
  - If a flag is granted and re-raised on the same edge, the flag stays set and there is no overflow.
- FIFO:
  - Pop = evt_valid & evt_ready.
  - evt_code and evt_long reflect the head entry. They are held stable while evt_valid=1 and evt_ready=0.
  - Push and pop in the same cycle leave the occupancy unchanged.
  - Pop on an empty FIFO is ignored.
- Latency: key_lvl first sampled high at edge k -> pend set after k -> evt_valid=1 after k+1, when the FIFO was empty and no lower-index key was pending.
- Counters are sized to ceil(log2(max(LONG_CNT, REPEAT_CNT))) bits. No wrap is possible, since each counter clears at its terminal count.

Decomposition:
- Shared package holds:
  - channel state typedef {IDLE, HOLD, REPEAT};
  - the event record typedef {code, long};
  - default timing constants for the 125 MHz clock.
- One natural sub-module, key_evt_chan: the per-key FSM plus counter, instantiated NKEY times via generate.
- Arbiter and FIFO stay in the top level.

Test Plan (LONG_CNT=10, REPEAT_CNT=4, FIFO_DEPTH=4, NKEY=4):
1. Key 2 high for 5 cycles, then low; evt_ready=1 -> exactly one event {code=2, long=0}, evt_valid high 2 cycles after the first high sample, no long event.
2. Key 0 high for 30 cycles; evt_ready=1 -> events in order: short, long at +10 cycles, then long every 4 cycles (4 long events); none after release.
3. Keys 3, 1, 0 rise on the same cycle; evt_ready=1 -> codes delivered in order 0, 1, 3 on consecutive cycles.
4. evt_ready=0; presses on keys 0, 1, 2, 3, then key 0 again -> fifo_full=1 after 4 pushes; second key-0 event sits pending; a third key-0 press pulses evt_ovf once; raising evt_ready drains codes 0, 1, 2, 3, 0.
5. FIFO full, pend[1] set, evt_ready=1 for one cycle -> pop and push on the same edge, fifo_full remains 1, no event lost.
6. Key 2 held, rst_n pulsed low mid-HOLD -> all outputs 0 during reset; after release, no event while key 2 stays high; release and re-press gives {code=2, long=0}.
